// File: rtl/ipsa_pkg.sv
// Shared types and constants for the AXI-Stream to IPSA ingress adapter.
package ipsa_pkg;

    localparam int AXIS_W_DEF = 512;
    localparam int IPSA_W_DEF = 1024;

    typedef enum logic {
        ACCUM   = 1'b0,
        DISCARD = 1'b1
    } adapt_state_e;

    // Word layout at the default widths; parameterised instances use flat vectors.
    typedef struct packed {
        logic [IPSA_W_DEF-1:0]   data;
        logic [IPSA_W_DEF/8-1:0] keep;
        logic                    last;
    } ipsa_word_t;

    function automatic int ratio(input int axis_w, input int ipsa_w);
        return ipsa_w / axis_w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count enabled events, holding at the maximum value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/axis_ipsa_in_adapter.sv
// Packs RATIO AXI-Stream beats into one IPSA word with keep mask, stall
// backpressure and truncation of packets longer than MAX_WORDS words.
module axis_ipsa_in_adapter
    import ipsa_pkg::*;
#(
    parameter int AXIS_W    = AXIS_W_DEF,
    parameter int IPSA_W    = IPSA_W_DEF,
    parameter int MAX_WORDS = 4,
    parameter int CNT_W     = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [AXIS_W-1:0]   s_axis_tdata,
    input  logic [AXIS_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    input  logic                ipsa_stall,
    output logic                ipsa_en_out,
    output logic [IPSA_W-1:0]   ipsa_data_out,
    output logic [IPSA_W/8-1:0] ipsa_keep_out,
    output logic                ipsa_last_out,
    output logic [CNT_W-1:0]    pkt_cnt,
    output logic [CNT_W-1:0]    trunc_cnt
);

    localparam int RATIO  = ratio(AXIS_W, IPSA_W);
    localparam int KEEP_W = AXIS_W / 8;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int WI_W   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);
    localparam logic [WI_W-1:0]   WI_LAST   = WI_W'(MAX_WORDS - 1);

    adapt_state_e          state_r;
    logic [LANE_W-1:0]     lane_r;
    logic [WI_W-1:0]       wi_r;
    logic [IPSA_W-1:0]     acc_data_r;
    logic [IPSA_W/8-1:0]   acc_keep_r;
    logic                  out_valid_r;
    logic [IPSA_W-1:0]     out_data_r;
    logic [IPSA_W/8-1:0]   out_keep_r;
    logic                  out_last_r;

    logic                  ready_s;
    logic                  accept_s;
    logic                  complete_s;
    logic                  trunc_s;
    logic                  emit_s;
    logic [IPSA_W-1:0]     fill_data_s;
    logic [IPSA_W/8-1:0]   fill_keep_s;

    // Ready: always drain in DISCARD; otherwise block only when the held word cannot leave.
    always_comb begin
        if (reset) begin
            ready_s = 1'b0;
        end else if (state_r == DISCARD) begin
            ready_s = 1'b1;
        end else begin
            ready_s = !(out_valid_r && ipsa_stall);
        end
    end

    // Merge the incoming beat into its lane and decode completion/truncation.
    always_comb begin
        fill_data_s = acc_data_r;
        fill_keep_s = acc_keep_r;
        fill_data_s[int'(lane_r)*AXIS_W +: AXIS_W] = s_axis_tdata;
        fill_keep_s[int'(lane_r)*KEEP_W +: KEEP_W] = s_axis_tkeep;
        accept_s   = s_axis_tvalid && ready_s;
        complete_s = accept_s && (state_r == ACCUM) &&
                     ((lane_r == LANE_LAST) || s_axis_tlast);
        trunc_s    = complete_s && !s_axis_tlast && (wi_r == WI_LAST);
        emit_s     = out_valid_r && !ipsa_stall;
    end

    // Accumulator, lane/word indices and packet state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ACCUM;
            lane_r     <= '0;
            wi_r       <= '0;
            acc_data_r <= '0;
            acc_keep_r <= '0;
        end else if (accept_s) begin
            case (state_r)
                ACCUM: begin
                    if (complete_s) begin
                        // Cleared accumulator guarantees zero upper lanes on short words.
                        acc_data_r <= '0;
                        acc_keep_r <= '0;
                        lane_r     <= '0;
                        if (s_axis_tlast) begin
                            wi_r <= '0;
                        end else if (wi_r == WI_LAST) begin
                            wi_r    <= '0;
                            state_r <= DISCARD;
                        end else begin
                            wi_r <= wi_r + WI_W'(1);
                        end
                    end else begin
                        acc_data_r <= fill_data_s;
                        acc_keep_r <= fill_keep_s;
                        lane_r     <= lane_r + LANE_W'(1);
                    end
                end
                DISCARD: begin
                    if (s_axis_tlast) begin
                        state_r <= ACCUM;
                    end else begin
                        state_r <= DISCARD;
                    end
                end
                default: begin
                    state_r <= ACCUM;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Output register: load on completion (even while draining), clear when emitted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_keep_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (complete_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= fill_data_s;
            out_keep_r  <= fill_keep_s;
            out_last_r  <= s_axis_tlast || (wi_r == WI_LAST);
        end else if (emit_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign s_axis_tready = ready_s;
    assign ipsa_en_out   = emit_s;
    assign ipsa_data_out = out_data_r;
    assign ipsa_keep_out = out_keep_r;
    assign ipsa_last_out = out_last_r;

    sat_counter #(.W(CNT_W)) u_pkt_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (emit_s && out_last_r),
        .count (pkt_cnt)
    );

    sat_counter #(.W(CNT_W)) u_trunc_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (trunc_s),
        .count (trunc_cnt)
    );

endmodule
